// File: rtl/axo_muldiv_if.sv
// Request/response bundle for the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
`timescale 1ns/1ps
interface axo_muldiv_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [TAGW-1:0] in_tag;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic [TAGW-1:0] out_tag;
    logic            out_illegal;

    // Requester side (pipeline issuing M-extension ops)
    modport master (
        output in_valid, funct3, in1, in2, in_tag, kill, out_ready,
        input  in_ready, out_valid, out, out_tag, out_illegal
    );

    // Execution unit side
    modport slave (
        input  in_valid, funct3, in1, in2, in_tag, kill, out_ready,
        output in_ready, out_valid, out, out_tag, out_illegal
    );
endinterface

// File: rtl/axo_muldiv.sv
// RV M-extension multiply/divide: radix-2 shift-add multiply and restoring divide on magnitudes.
// Latency: out_valid rises XLEN+1 edges after accept; unsupported ops 1 edge after accept.
// Backpressure: one op in flight; in_ready low until DONE is drained by out_ready. Define AXO_MULDIV_DIV_EN to build the divider.
`timescale 1ns/1ps
module axo_muldiv #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic        clk,
    input  logic        rst,
    axo_muldiv_if.slave io_bus
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;      // multiplicand, or divisor, magnitude
    logic [XLEN-1:0] r_hi;     // product high half / partial remainder
    logic [XLEN-1:0] r_lo;     // multiplier being consumed / quotient being built
    logic            r_neg;    // final result must be negated
    logic [CW-1:0]   r_cnt;
    logic [TAGW-1:0] r_tag;
    logic [XLEN-1:0] r_out;
    logic            r_ill;

    logic            w_acc;
    logic            w_is_div;
    logic            w_s1;
    logic            w_s2;
    logic            w_n1;
    logic            w_n2;
    logic [XLEN-1:0] w_m1;
    logic [XLEN-1:0] w_m2;
    logic [XLEN:0]   w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_res;

    assign w_acc    = io_bus.in_valid & (r_state == S_IDLE) & ~io_bus.kill;
    assign w_is_div = io_bus.funct3[2];

    // Which operands are signed: MUL/MULH both, MULHSU rs1 only, MULHU none; DIV/REM both, DIVU/REMU none.
    assign w_s1 = w_is_div ? ~io_bus.funct3[0] : (io_bus.funct3[1:0] != 2'b11);
    assign w_s2 = w_is_div ? ~io_bus.funct3[0] : ~io_bus.funct3[1];
    assign w_n1 = w_s1 & io_bus.in1[XLEN-1];
    assign w_n2 = w_s2 & io_bus.in2[XLEN-1];
    assign w_m1 = w_n1 ? -io_bus.in1 : io_bus.in1;
    assign w_m2 = w_n2 ? -io_bus.in2 : io_bus.in2;

    // Shift-add step: conditionally add multiplicand into the high half, then shift the pair right.
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

`ifdef AXO_MULDIV_DIV_EN
    logic            r_dz;
    logic [XLEN:0]   w_rem;
    logic [XLEN:0]   w_dif;
    logic            w_ge;
    logic [XLEN-1:0] w_q;
    logic [XLEN-1:0] w_r;

    // Restoring step: bring in next dividend bit, subtract divisor if it fits.
    assign w_rem = {r_hi, r_lo[XLEN-1]};
    assign w_dif = w_rem - {1'b0, r_a};
    assign w_ge  = ~w_dif[XLEN];
    assign w_q   = r_neg ? -r_lo : r_lo;
    assign w_r   = r_neg ? -r_hi : r_hi;
`endif

    // Final result select with sign fix. A zero divisor leaves the remainder equal to the
    // dividend naturally, and the overflow case produces -2^(XLEN-1) and 0 naturally; only the
    // signed divide-by-zero quotient needs forcing to all ones.
    always_comb begin
        w_res = '0;
        if (r_op[2]) begin
`ifdef AXO_MULDIV_DIV_EN
            if (r_op[1])   w_res = w_r;
            else if (r_dz) w_res = '1;
            else           w_res = w_q;
`endif
        end else if (r_op[1:0] == 2'b00) begin
            w_res = w_prod[XLEN-1:0];
        end else begin
            w_res = w_prod[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs; kill overrides everything.
    always_comb begin
        w_next           = r_state;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                io_bus.in_ready = 1'b1;
                if (w_acc) begin
`ifdef AXO_MULDIV_DIV_EN
                    w_next = S_CALC;
`else
                    // Unsupported op: bypass CALC and use the FIX slot only to load a zero result.
                    w_next = w_is_div ? S_FIX : S_CALC;
`endif
                end
            end
            S_CALC: if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: begin
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (io_bus.kill) w_next = S_IDLE;
    end

    // Operand capture at accept, one iteration per CALC cycle, result register in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
            r_tag <= '0;
            r_out <= '0;
            r_ill <= 1'b0;
`ifdef AXO_MULDIV_DIV_EN
            r_dz  <= 1'b0;
`endif
        end else if (w_acc) begin
            r_op  <= io_bus.funct3;
            r_tag <= io_bus.in_tag;
            r_cnt <= '0;
            r_hi  <= '0;
            r_ill <= 1'b0;
            if (w_is_div) begin
                r_a   <= w_m2;
                r_lo  <= w_m1;
                // Quotient sign is the xor of signs; remainder follows the dividend.
                r_neg <= io_bus.funct3[1] ? w_n1 : (w_n1 ^ w_n2);
`ifdef AXO_MULDIV_DIV_EN
                r_dz  <= (io_bus.in2 == '0);
`else
                r_ill <= 1'b1;
`endif
            end else begin
                r_a   <= w_m1;
                r_lo  <= w_m2;
                r_neg <= w_n1 ^ w_n2;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op[2]) begin
`ifdef AXO_MULDIV_DIV_EN
                r_hi <= w_ge ? w_dif[XLEN-1:0] : w_rem[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
`endif
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == S_FIX && !io_bus.kill) begin
            r_out <= w_res;
        end
    end

    assign io_bus.out         = r_out;
    assign io_bus.out_tag     = r_tag;
    assign io_bus.out_illegal = r_ill;
endmodule

// File: tb/tb_axo_muldiv.sv
`timescale 1ns/1ps
module tb_axo_muldiv;
    localparam int XLEN = 32;
    localparam int TAGW = 5;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t vt[$];

    axo_muldiv_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    axo_muldiv #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: {illegal, result} from plain 64-bit arithmetic.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [32:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = '0;
        up = '0;
        r  = '0;
        case (op)
            3'd0: begin sp = sa * sb; r = {1'b0, sp[31:0]}; end
            3'd1: begin sp = sa * sb; r = {1'b0, sp[63:32]}; end
            3'd2: begin sp = sa * $signed({32'b0, b}); r = {1'b0, sp[63:32]}; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = {1'b0, up[63:32]}; end
`ifdef AXO_MULDIV_DIV_EN
            3'd4: begin
                if (b == 32'd0) r = {1'b0, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {1'b0, 32'h80000000};
                else begin sp = sa / sb; r = {1'b0, sp[31:0]}; end
            end
            3'd5: r = (b == 32'd0) ? {1'b0, 32'hFFFFFFFF} : {1'b0, a / b};
            3'd6: begin
                if (b == 32'd0) r = {1'b0, a};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 33'd0;
                else begin sp = sa % sb; r = {1'b0, sp[31:0]}; end
            end
            default: r = (b == 32'd0) ? {1'b0, a} : {1'b0, a % b};
`else
            default: r = {1'b1, 32'h0};
`endif
        endcase
        return r;
    endfunction

    function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] res, input logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compare each new result against the head of the scoreboard.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.out_valid && !prev_v) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", bus.out, e.res);
                        chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
                        chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end
                prev_v = bus.out_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Present a request at a falling edge; returns at the falling edge after the accept edge.
    task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int acc);
        chk("in_ready_before_offer", 32'(bus.in_ready), 32'd1);
        bus.funct3   = op;
        bus.in1      = a;
        bus.in2      = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom());
        bus.in1      = $urandom();
        bus.in2      = $urandom();
        bus.in_tag   = 5'($urandom());
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold,
                         input logic [31:0] exp_res, input logic exp_ill);
        int   acc;
        int   n;
        exp_t e;
        offer(op, a, b, tag, acc);
        e.res = exp_res; e.tag = tag; e.ill = exp_ill; e.acc = acc;
        e.lat = exp_ill ? 1 : XLEN + 1;
        sbq.push_back(e);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            bus.in1 = $urandom();
            bus.in2 = $urandom();
            n++;
        end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_out", bus.out, exp_res);
                chk("hold_out_tag", 32'(bus.out_tag), 32'(tag));
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
                @(negedge clk);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("in_ready_after_take", 32'(bus.in_ready), 32'd1);
            chk("out_valid_after_take", 32'(bus.out_valid), 32'd0);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        int          acc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] m;

        bus.in_valid = 1'b0; bus.kill = 1'b0; bus.out_ready = 1'b0;
        bus.funct3 = 3'd0; bus.in1 = '0; bus.in2 = '0; bus.in_tag = '0;

        vt.push_back(mkv(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0));
        vt.push_back(mkv(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0));
        vt.push_back(mkv(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0));
        vt.push_back(mkv(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
`ifdef AXO_MULDIV_DIV_EN
        vt.push_back(mkv(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0));
        vt.push_back(mkv(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0));
        vt.push_back(mkv(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0));
        vt.push_back(mkv(3'd7, 32'd5,        32'd0,        32'd5,        1'b0));
        vt.push_back(mkv(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0));
        vt.push_back(mkv(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0));
`else
        vt.push_back(mkv(3'd5, 32'd9,        32'd3,        32'd0,        1'b1));
        vt.push_back(mkv(3'd0, 32'd7,        32'd3,        32'd21,       1'b0));
`endif

        // Reset values while rst is held
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", bus.out, 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; the first one holds the result for 5 cycles
        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), (i == 0) ? 5 : 0, vt[i].res, vt[i].ill);
        end

        // Kill at CALC iteration 10
        offer(3'd0, 32'h1234, 32'h5678, 5'h0A, acc);
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        chk("kill_in_ready", 32'(bus.in_ready), 32'd1);
        chk("kill_out_valid", 32'(bus.out_valid), 32'd0);
        bus.kill = 1'b0;
        repeat (40) @(negedge clk);
        do_op(3'd0, 32'd7, 32'd3, 5'h1B, 0, 32'd21, 1'b0);

        // Kill together with an offered request in IDLE drops it
        bus.funct3 = 3'd0; bus.in1 = 32'd9; bus.in2 = 32'd9; bus.in_tag = 5'h03;
        bus.in_valid = 1'b1;
        bus.kill = 1'b1;
        @(negedge clk);
        chk("kill_idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        bus.kill = 1'b0;
        repeat (40) @(negedge clk);

        // Reset pulse mid-CALC
        offer(3'd1, 32'h00012345, 32'h00067890, 5'h15, acc);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out", bus.out, 32'd0);
        chk("midrst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("midrst_out_illegal", 32'(bus.out_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            m  = model(op, a, b);
            do_op(op, a, b, 5'($urandom()), (i % 7 == 3) ? 2 : 0, m[31:0], m[32]);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
